// File: rtl/half_adder.sv
// half_adder: lane-replicated half adder with a one-cycle registered copy of the result
// and a saturating counter of accepted cycles in which any lane carries.
module half_adder #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] c_out,
   input  logic             in_valid,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] c_out_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] carry_count
);
   assign sum   = a ^ b;
   assign c_out = a & b;
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         c_out_q     <= '0;
         out_valid   <= 1'b0;
         carry_count <= '0;
      end else begin
         if (in_valid) begin
            sum_q   <= sum;
            c_out_q <= c_out;
         end
         out_valid <= in_valid;
         // one increment per cycle however many lanes carry; sticks at all-ones
         carry_count <= cnt_clr ? '0
                      : (in_valid && |c_out && carry_count != '1) ? carry_count + CNT_W'(1)
                      : carry_count;
      end
   end
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed and randomized checks of half_adder at WIDTH=1/CNT_W=16,
// WIDTH=1/CNT_W=2 (saturation) and WIDTH=4/CNT_W=8 against an arithmetic reference model.
module tb_half_adder;
   logic       clk = 1'b0;
   logic       rst, in_valid, cnt_clr;
   logic       a1, b1;
   logic [3:0] a4, b4;
   logic       sum1, c1, sq1, cq1, ov1;
   logic       sum_s, c_s, sq_s, cq_s, ov_s;
   logic [3:0] sum4, c4, sq4, cq4;
   logic       ov4;
   logic [15:0] cnt16;
   logic [1:0]  cnt2;
   logic [7:0]  cnt8;
   int checks = 0, errors = 0;
   int m_sq1, m_cq1, m_ov, m_sq4, m_cq4, m_cnt16, m_cnt2, m_cnt8;

   always #5 clk = ~clk;

   half_adder #(.WIDTH(1), .CNT_W(16)) u_w1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .sum(sum1), .c_out(c1), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .sum_q(sq1), .c_out_q(cq1), .out_valid(ov1), .carry_count(cnt16));
   half_adder #(.WIDTH(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .sum(sum_s), .c_out(c_s), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .sum_q(sq_s), .c_out_q(cq_s), .out_valid(ov_s), .carry_count(cnt2));
   half_adder #(.WIDTH(4), .CNT_W(8)) u_w4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .sum(sum4), .c_out(c4), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .sum_q(sq4), .c_out_q(cq4), .out_valid(ov4), .carry_count(cnt8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // expected lane results from plain addition: a + b = 2*carry + sum
   function automatic logic [3:0] lane_sum(input logic [3:0] x, input logic [3:0] y);
      for (int i = 0; i < 4; i++) lane_sum[i] = ((int'(x[i]) + int'(y[i])) % 2) == 1;
   endfunction
   function automatic logic [3:0] lane_carry(input logic [3:0] x, input logic [3:0] y);
      for (int i = 0; i < 4; i++) lane_carry[i] = (int'(x[i]) + int'(y[i])) == 2;
   endfunction

   task automatic comb();
      #1;
      chk("sum1", 32'(sum1), 32'((int'(a1) + int'(b1)) % 2));
      chk("c1", 32'(c1), 32'((int'(a1) + int'(b1)) / 2));
      chk("sum_sat", 32'(sum_s), 32'((int'(a1) + int'(b1)) % 2));
      chk("c_sat", 32'(c_s), 32'((int'(a1) + int'(b1)) / 2));
      chk("sum4", 32'(sum4), 32'(lane_sum(a4, b4)));
      chk("c4", 32'(c4), 32'(lane_carry(a4, b4)));
   endtask

   function automatic int sat_inc(input int v, input int bits);
      return (v + 1 > (1 << bits) - 1) ? v : v + 1;
   endfunction

   task automatic tick();
      bit car1 = (int'(a1) + int'(b1)) == 2;
      bit car4 = lane_carry(a4, b4) != 0;
      if (rst) begin
         {m_sq1, m_cq1, m_ov, m_sq4, m_cq4, m_cnt16, m_cnt2, m_cnt8} = '0;
      end else begin
         if (in_valid) begin
            m_sq1 = (int'(a1) + int'(b1)) % 2;
            m_cq1 = (int'(a1) + int'(b1)) / 2;
            m_sq4 = int'(lane_sum(a4, b4));
            m_cq4 = int'(lane_carry(a4, b4));
         end
         m_ov = int'(in_valid);
         if (cnt_clr) begin
            m_cnt16 = 0; m_cnt2 = 0; m_cnt8 = 0;
         end else if (in_valid) begin
            if (car1) begin m_cnt16 = sat_inc(m_cnt16, 16); m_cnt2 = sat_inc(m_cnt2, 2); end
            if (car4) m_cnt8 = sat_inc(m_cnt8, 8);
         end
      end
      @(posedge clk);
      #1;
      chk("sum_q1", 32'(sq1), m_sq1);
      chk("c_out_q1", 32'(cq1), m_cq1);
      chk("out_valid1", 32'(ov1), m_ov);
      chk("cnt16", 32'(cnt16), m_cnt16);
      chk("sum_q_sat", 32'(sq_s), m_sq1);
      chk("c_out_q_sat", 32'(cq_s), m_cq1);
      chk("out_valid_sat", 32'(ov_s), m_ov);
      chk("cnt2", 32'(cnt2), m_cnt2);
      chk("sum_q4", 32'(sq4), m_sq4);
      chk("c_out_q4", 32'(cq4), m_cq4);
      chk("out_valid4", 32'(ov4), m_ov);
      chk("cnt8", 32'(cnt8), m_cnt8);
   endtask

   initial begin
      logic [1:0] pair;
      logic [3:0] ex_sum = 4'b0110;
      logic [3:0] ex_car = 4'b1000;
      rst = 1; in_valid = 0; cnt_clr = 0; a1 = 0; b1 = 0; a4 = 0; b4 = 0;
      tick(); tick();
      chk("reset_cnt16", 32'(cnt16), 0);
      chk("reset_ov", 32'(ov1), 0);
      rst = 0;
      // exhaustive single-lane truth table, each pair held one period
      for (int p = 0; p < 4; p++) begin
         pair = 2'(p);
         a1 = pair[1]; b1 = pair[0];
         comb();
         chk("tt_sum", 32'(sum1), 32'(ex_sum[p]));
         chk("tt_c", 32'(c1), 32'(ex_car[p]));
         tick();
      end
      a1 = 1; b1 = 1; in_valid = 1; comb(); tick();
      chk("reg_sum_q", 32'(sq1), 0);
      chk("reg_c_out_q", 32'(cq1), 1);
      chk("reg_out_valid", 32'(ov1), 1);
      in_valid = 0; a1 = 0; comb(); tick();
      chk("hold_c_out_q", 32'(cq1), 1);
      chk("hold_out_valid", 32'(ov1), 0);
      cnt_clr = 1; tick(); cnt_clr = 0;
      a1 = 1; b1 = 1; in_valid = 1;
      repeat (5) begin comb(); tick(); end
      b1 = 0;
      repeat (3) begin comb(); tick(); end
      chk("count5", 32'(cnt16), 5);
      b1 = 1; cnt_clr = 1; comb(); tick(); cnt_clr = 0;
      chk("clr_priority", 32'(cnt16), 0);
      repeat (6) begin comb(); tick(); end
      chk("saturate", 32'(cnt2), 3);
      rst = 1; comb();
      chk("rst_sum_comb", 32'(sum1), 0);
      chk("rst_c_comb", 32'(c1), 1);
      tick(); rst = 0;
      chk("rst_cnt", 32'(cnt16), 0);
      chk("rst_out_valid", 32'(ov1), 0);
      chk("rst_c_out_q", 32'(cq1), 0);
      a4 = 4'b1100; b4 = 4'b1010; in_valid = 1; comb();
      chk("w4_sum", 32'(sum4), 32'h6);
      chk("w4_c", 32'(c4), 32'h8);
      tick();
      chk("w4_cnt_one", 32'(cnt8), 1);
      repeat (300) begin
         a1 = 1'($urandom); b1 = 1'($urandom);
         a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
         in_valid = 1'($urandom); cnt_clr = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 31) == 0);
         comb();
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
